onehot_pulse_decoder: RTL and testbench

- Reverse direction of the team's 8:3 priority encoder.
- Accepts a 3-bit index through a valid/ready handshake and drives the matching bit of an 8-bit one-hot output for a programmable number of cycles.
- After the drive window it inserts an optional idle gap, then accepts the next index.
- Sits downstream of the encoder: the encoder's out/valid pair feeds in_code/in_valid, and the block turns the selected request back into a timed one-hot strobe, e.g. a grant or service pulse.

---
 rtl/onehot_pulse_decoder_pkg.sv | 25 ++
 rtl/onehot_pulse_decoder_if.sv | 26 ++
 rtl/onehot_pulse_decoder_cycle_down_counter.sv | 32 +++
 rtl/onehot_pulse_decoder.sv | 153 +++++++++++++++
 tb/tb_onehot_pulse_decoder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/onehot_pulse_decoder_pkg.sv
// onehot_pulse_decoder_pkg
// Shared definitions for the one-hot pulse decoder and its upstream 8:3
// priority encoder.
//   CODE_W / ONEHOT_W : index width and one-hot width. Both ends must agree.
//   state_t           : controller states (idle, driving, inter-request gap).
//   idx_to_onehot     : pure index-to-one-hot conversion.
package onehot_pulse_decoder_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP
    } state_t;

    function automatic logic [ONEHOT_W-1:0] idx_to_onehot(input logic [CODE_W-1:0] code);
        logic [ONEHOT_W-1:0] result;
        result       = '0;
        result[code] = 1'b1;
        return result;
    endfunction

endpackage

// File: rtl/onehot_pulse_decoder_if.sv
// onehot_pulse_decoder_if
// Valid/ready request channel into the decoder.
//   in_code  : index to decode (source -> decoder)
//   in_valid : request present (source -> decoder)
//   in_ready : decoder can accept this cycle (decoder -> source)
// Modports: master = request source (e.g. the priority encoder), slave = decoder.
interface onehot_pulse_decoder_if;
    import onehot_pulse_decoder_pkg::*;

    logic [CODE_W-1:0] in_code;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_code,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_code,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/onehot_pulse_decoder_cycle_down_counter.sv
// cycle_down_counter
// Loadable 8-bit down-counter with a zero flag. Used by the decoder to time
// both the drive window and the idle gap.
//   clk, rst   : clock and asynchronous active-high reset (clears to zero)
//   load       : load load_value this edge (has priority over dec)
//   load_value : value to load
//   dec        : decrement this edge; the count stops at zero
//   count      : current count
//   zero       : high while count is zero
module cycle_down_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       dec,
    output logic [7:0] count,
    output logic       zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder
// Accepts a 3-bit index over a valid/ready handshake and drives the matching
// bit of an 8-bit one-hot output for HOLD cycles. It then idles for GAP
// cycles before it accepts the next index.
//   clk, rst   : clock and asynchronous active-high reset
//   hs         : request channel (slave side): in_code, in_valid, in_ready
//   out        : registered one-hot drive, zero when not driving
//   out_active : high exactly while out is non-zero
//   done       : one-cycle pulse in the last drive cycle of each request
//   busy       : high in the drive and gap states
//   req_count  : accepted-request counter, wraps silently
// Parameters: HOLD (1..255), GAP (0..255), CNT_W (req_count width).
module onehot_pulse_decoder
    import onehot_pulse_decoder_pkg::*;
#(
    parameter int HOLD  = 4,
    parameter int GAP   = 1,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    onehot_pulse_decoder_if.slave hs,
    output logic [ONEHOT_W-1:0]   out,
    output logic                  out_active,
    output logic                  done,
    output logic                  busy,
    output logic [CNT_W-1:0]      req_count
);

    // The counters hold "cycles remaining after this one", so they load N-1.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_t              state;
    state_t              state_next;
    logic [ONEHOT_W-1:0] out_next;
    logic                active_next;
    logic                done_next;
    logic                accept;
    logic                req_inc;

    logic                hold_load;
    logic                hold_dec;
    logic [7:0]          hold_cnt;
    logic                hold_zero;
    logic                gap_load;
    logic                gap_dec;
    logic [7:0]          gap_count_unused;
    logic                gap_zero;

    cycle_down_counter u_hold_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .load_value (HOLD_LOAD),
        .dec        (hold_dec),
        .count      (hold_cnt),
        .zero       (hold_zero)
    );

    // Only the zero flag matters for the gap. The count itself is not read.
    cycle_down_counter u_gap_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (gap_load),
        .load_value (GAP_LOAD),
        .dec        (gap_dec),
        .count      (gap_count_unused),
        .zero       (gap_zero)
    );

    // in_ready is a register that tracks the IDLE state, so a handshake can
    // only complete in IDLE. It is also low in the cycle that follows reset.
    assign accept = hs.in_valid && hs.in_ready;

    // done is registered. It is set on the edge that brings the hold count to
    // zero, so it lines up with the last drive cycle. For HOLD=1 that is the
    // accepting edge itself.
    always_comb begin
        state_next  = state;
        out_next    = out;
        active_next = out_active;
        done_next   = 1'b0;
        req_inc     = 1'b0;
        hold_load   = 1'b0;
        hold_dec    = 1'b0;
        gap_load    = 1'b0;
        gap_dec     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next  = ST_DRIVE;
                    out_next    = idx_to_onehot(hs.in_code);
                    active_next = 1'b1;
                    req_inc     = 1'b1;
                    hold_load   = 1'b1;
                    done_next   = (HOLD_LOAD == 8'd0);
                end
            end
            ST_DRIVE: begin
                if (hold_zero) begin
                    out_next    = '0;
                    active_next = 1'b0;
                    if (GAP > 0) begin
                        state_next = ST_GAP;
                        gap_load   = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    hold_dec  = 1'b1;
                    done_next = (hold_cnt == 8'd1);
                end
            end
            ST_GAP: begin
                if (gap_zero) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                out_next    = '0;
                active_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            out         <= '0;
            out_active  <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            hs.in_ready <= 1'b0;
            req_count   <= '0;
        end else begin
            state       <= state_next;
            out         <= out_next;
            out_active  <= active_next;
            done        <= done_next;
            busy        <= (state_next != ST_IDLE);
            hs.in_ready <= (state_next == ST_IDLE);
            if (req_inc) begin
                req_count <= req_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb_onehot_pulse_decoder
// Directed bench for onehot_pulse_decoder. dut_a uses HOLD=4, GAP=1 and
// dut_b uses HOLD=1, GAP=0. A table drives the first request. Hand-written
// sequences then cover the code sweep, stall, back-to-back streaming,
// asynchronous reset and counter wrap.
module tb_onehot_pulse_decoder;
    import onehot_pulse_decoder_pkg::*;

    localparam int HOLD_A = 4;
    localparam int GAP_A  = 1;
    localparam int HOLD_B = 1;
    localparam int GAP_B  = 0;
    localparam int CNT_W  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] out_a;
    logic       active_a;
    logic       done_a;
    logic       busy_a;
    logic [7:0] req_a;
    logic [7:0] out_b;
    logic       active_b;
    logic       done_b;
    logic       busy_b;
    logic [7:0] req_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] onehot_ref [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                   8'h10, 8'h20, 8'h40, 8'h80};

    typedef struct {
        logic [2:0] code;
        logic       valid;
        logic [7:0] exp_out;
        logic       exp_active;
        logic       exp_done;
        logic       exp_ready;
        logic       exp_busy;
        logic [7:0] exp_req;
    } vec_t;

    vec_t tbl [8];

    onehot_pulse_decoder_if hs_a ();
    onehot_pulse_decoder_if hs_b ();

    onehot_pulse_decoder #(.HOLD(HOLD_A), .GAP(GAP_A), .CNT_W(CNT_W)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .hs         (hs_a),
        .out        (out_a),
        .out_active (active_a),
        .done       (done_a),
        .busy       (busy_a),
        .req_count  (req_a)
    );

    onehot_pulse_decoder #(.HOLD(HOLD_B), .GAP(GAP_B), .CNT_W(CNT_W)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .hs         (hs_b),
        .out        (out_b),
        .out_active (active_b),
        .done       (done_b),
        .busy       (busy_b),
        .req_count  (req_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel_b, input logic [2:0] code, input logic valid);
        if (sel_b) begin
            hs_b.in_code  = code;
            hs_b.in_valid = valid;
        end else begin
            hs_a.in_code  = code;
            hs_a.in_valid = valid;
        end
    endtask

    task automatic checkDut(input bit sel_b, input string tag, input logic [7:0] e_out,
                            input logic e_act, input logic e_done, input logic e_ready,
                            input logic e_busy, input logic [7:0] e_req);
        logic [7:0] a_out;
        logic [7:0] a_req;
        logic       a_act;
        logic       a_done;
        logic       a_ready;
        logic       a_busy;
        if (sel_b) begin
            a_out = out_b; a_act = active_b; a_done = done_b;
            a_ready = hs_b.in_ready; a_busy = busy_b; a_req = req_b;
        end else begin
            a_out = out_a; a_act = active_a; a_done = done_a;
            a_ready = hs_a.in_ready; a_busy = busy_a; a_req = req_a;
        end
        checkOutput({tag, ".out"},        int'(a_out),   int'(e_out));
        checkOutput({tag, ".out_active"}, int'(a_act),   int'(e_act));
        checkOutput({tag, ".done"},       int'(a_done),  int'(e_done));
        checkOutput({tag, ".in_ready"},   int'(a_ready), int'(e_ready));
        checkOutput({tag, ".busy"},       int'(a_busy),  int'(e_busy));
        checkOutput({tag, ".req_count"},  int'(a_req),   int'(e_req));
    endtask

    // Entry and exit are both at a negedge where dut_a is idle and ready.
    // After the first drive cycle the inputs switch to next_code/keep_valid.
    task automatic runRequestA(input logic [2:0] code, input logic [2:0] next_code,
                               input logic keep_valid, input logic [7:0] exp_req,
                               input string tag);
        checkOutput({tag, ".ready_in"}, int'(hs_a.in_ready), 1);
        applyStimulus(1'b0, code, 1'b1);
        @(negedge clk);
        for (int h = 0; h < HOLD_A; h++) begin
            checkDut(1'b0, $sformatf("%s.drive%0d", tag, h), onehot_ref[code],
                     1'b1, (h == HOLD_A - 1), 1'b0, 1'b1, exp_req);
            if (h == 0) applyStimulus(1'b0, next_code, keep_valid);
            @(negedge clk);
        end
        for (int g = 0; g < GAP_A; g++) begin
            checkDut(1'b0, $sformatf("%s.gap%0d", tag, g), 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, exp_req);
            @(negedge clk);
        end
        checkDut(1'b0, {tag, ".idle"}, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, exp_req);
    endtask

    // Invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("inv_a.onehot0", int'($onehot0(out_a)), 1);
            checkOutput("inv_a.active",  int'(active_a), int'(out_a != 8'h00));
            checkOutput("inv_a.done",    int'(done_a && !active_a), 0);
            checkOutput("inv_b.onehot0", int'($onehot0(out_b)), 1);
            checkOutput("inv_b.active",  int'(active_b), int'(out_b != 8'h00));
            checkOutput("inv_b.done",    int'(done_b && !active_b), 0);
        end
    end

    initial begin
        // Single request, code 5, on the HOLD=4 GAP=1 instance.
        tbl[0] = '{3'd5, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[1] = '{3'd0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[2] = '{3'd0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[3] = '{3'd0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[4] = '{3'd0, 1'b0, 8'h20, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
        tbl[5] = '{3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[6] = '{3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[7] = '{3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};

        applyStimulus(1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 3'd0, 1'b0);

        // Reset state: everything low, including in_ready.
        @(negedge clk);
        checkDut(1'b0, "reset_a", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        checkDut(1'b1, "reset_b", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single request table");
        for (int i = 0; i < 8; i++) begin
            checkDut(1'b0, $sformatf("table%0d", i), tbl[i].exp_out, tbl[i].exp_active,
                     tbl[i].exp_done, tbl[i].exp_ready, tbl[i].exp_busy, tbl[i].exp_req);
            applyStimulus(1'b0, tbl[i].code, tbl[i].valid);
            @(negedge clk);
        end

        $display("[TB] sweep codes 0..7 with in_valid held");
        for (int k = 0; k < 8; k++) begin
            runRequestA(3'(k), (k == 7) ? 3'(k) : 3'(k + 1), (k != 7), 8'(2 + k), "sweep");
        end
        checkOutput("sweep.accepted", int'(req_a) - 1, 8);

        $display("[TB] stall: code changes 3 -> 6 while busy");
        runRequestA(3'd3, 3'd6, 1'b1, 8'd10, "stall_first");
        runRequestA(3'd6, 3'd6, 1'b0, 8'd11, "stall_second");

        $display("[TB] HOLD=1 GAP=0 stream");
        for (int j = 0; j < 8; j++) begin
            checkDut(1'b1, $sformatf("stream%0d.zero", j), 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'(j));
            applyStimulus(1'b1, 3'(j), 1'b1);
            @(negedge clk);
            checkDut(1'b1, $sformatf("stream%0d.drive", j), onehot_ref[j], 1'b1, 1'b1, 1'b0, 1'b1, 8'(j + 1));
            @(negedge clk);
        end
        applyStimulus(1'b1, 3'd0, 1'b0);

        $display("[TB] asynchronous reset mid-drive");
        applyStimulus(1'b0, 3'd2, 1'b1);
        @(negedge clk);
        checkDut(1'b0, "abort.drive0", 8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 8'd12);
        applyStimulus(1'b0, 3'd0, 1'b0);
        @(negedge clk);
        checkDut(1'b0, "abort.drive1", 8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 8'd12);
        #2 rst = 1'b1;
        #1;
        checkDut(1'b0, "abort.immediate", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        checkOutput("abort.req_b", int'(req_b), 0);
        @(negedge clk);
        checkDut(1'b0, "abort.held", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        checkDut(1'b0, "abort.recovered", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        runRequestA(3'd1, 3'd1, 1'b0, 8'd1, "resume");

        $display("[TB] req_count wrap");
        for (int n = 2; n <= 256; n++) begin
            runRequestA(3'(n), 3'(n), 1'b0, 8'(n), "wrap");
        end
        checkOutput("wrap.zero", int'(req_a), 0);
        runRequestA(3'd5, 3'd5, 1'b0, 8'd1, "wrap_257");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
